keycode_pio_fifo: RTL and testbench

//  Parametrised successor to the single-register keycode PIO. Avalon-MM slave that
//  the NIOS writes keyboard keycodes into, buffered in a DEPTH-entry FIFO and

---
 rtl/keycode_pio_fifo.sv | 88 ++++++++
 tb/tb_keycode_pio_fifo.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/keycode_pio_fifo.sv
// keycode_pio_fifo: Avalon-MM keycode PIO feeding a DEPTH-entry first-word-fall-through FIFO,
// with a held-key register, status/overflow reporting and flush.
module keycode_pio_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] held_key,
    output logic [DATA_W-1:0] key_data,
    output logic              key_valid,
    input  logic              key_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [DATA_W-1:0] r_last_key;
    logic [DATA_W-1:0] r_held_key;

    logic w_wr, w_push, w_flush, w_ovf_clr, w_hold;
    logic w_empty, w_full, w_pop, w_acc;
    logic w_unused_bits;

    assign w_wr      = chipselect && !write_n;
    assign w_push    = w_wr && address == 2'd0;
    assign w_flush   = w_wr && address == 2'd1 && writedata[0];
    assign w_ovf_clr = w_wr && address == 2'd1 && writedata[18];
    assign w_hold    = w_wr && address == 2'd2;
    assign w_empty   = r_count == '0;
    assign w_full    = r_count == FULL_CNT;
    assign w_pop     = key_valid && key_ready && !w_flush;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_acc     = w_push && (!w_full || w_pop);
    assign w_unused_bits = ^writedata;

    assign key_valid = !w_empty;
    assign key_data  = r_mem[r_rd_ptr];
    assign held_key  = r_held_key;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_last_key <= '0;
            r_held_key <= '0;
        end else begin
            if (w_push) r_last_key <= writedata[DATA_W-1:0];
            if (w_hold) r_held_key <= writedata[DATA_W-1:0];
            if (w_push && !w_acc) r_overflow <= 1'b1;
            else if (w_ovf_clr) r_overflow <= 1'b0;
            if (w_acc) r_mem[r_wr_ptr] <= writedata[DATA_W-1:0];
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= r_count + CW'(w_acc) - CW'(w_pop);
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (address == 2'd0) readdata[DATA_W-1:0] = r_last_key;
        else if (address == 2'd1) begin
            readdata[CW-1:0] = r_count;
            readdata[16]     = w_empty;
            readdata[17]     = w_full;
            readdata[18]     = r_overflow;
        end else if (address == 2'd2) readdata[DATA_W-1:0] = r_held_key;
    end
endmodule

// File: tb/tb_keycode_pio_fifo.sv
// tb_keycode_pio_fifo: scoreboard bench for keycode_pio_fifo (DATA_W=8, DEPTH=8).
module tb_keycode_pio_fifo;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  held_key, key_data;
    logic        key_valid;
    logic        key_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] q[$];
    logic [7:0] m_last = '0;
    logic [7:0] m_held = '0;
    logic       m_ovf  = 1'b0;

    keycode_pio_fifo #(.DATA_W(8), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .held_key(held_key), .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        logic [31:0] s = '0;
        s[3:0] = 4'(q.size());
        s[16]  = q.size() == 0;
        s[17]  = q.size() == 8;
        s[18]  = m_ovf;
        return s;
    endfunction

    // Updates the model for the coming edge, then advances one clock.
    task automatic tick();
        logic wr, flush, pop;
        wr    = chipselect && !write_n;
        flush = wr && address == 2'd1 && writedata[0];
        pop   = q.size() != 0 && key_ready && !flush;
        chk("key_valid", {31'b0, key_valid}, {31'b0, q.size() != 0});
        if (pop) begin
            chk("pop_data", {24'b0, key_data}, {24'b0, q[0]});
            void'(q.pop_front());
        end
        if (flush) q.delete();
        if (wr && address == 2'd0) begin
            m_last = writedata[7:0];
            if (q.size() < 8 || pop) q.push_back(writedata[7:0]);
            else m_ovf = 1'b1;
        end
        if (wr && address == 2'd1 && writedata[18]) m_ovf = 1'b0;
        if (wr && address == 2'd2) m_held = writedata[7:0];
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a; chipselect = 1'b1;
        #1;
        chk(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic rd_all();
        rd("last_key", 2'd0, {24'b0, m_last});
        rd("status", 2'd1, status_exp());
        rd("hold", 2'd2, {24'b0, m_held});
        rd("rsvd", 2'd3, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rd("rst_addr0", 2'd0, 32'h0);
        rd("rst_addr1", 2'd1, 32'h0001_0000);
        rd("rst_addr2", 2'd2, 32'h0);
        chk("rst_valid", {31'b0, key_valid}, 32'h0);
        chk("rst_held", {24'b0, held_key}, 32'h0);

        wr(2'd0, 32'h1A);
        chk("t2_data", {24'b0, key_data}, 32'h1A);
        rd("t2_status", 2'd1, 32'h0000_0001);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        rd("t2_status_empty", 2'd1, 32'h0001_0000);

        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 9; k++) wr(2'd0, 32'(k));
            rd("t3_status", 2'd1, 32'h0006_0008);
            rd("t3_last", 2'd0, 32'h09);
            key_ready = 1'b1;
            repeat (8) tick();
            key_ready = 1'b0;
            rd_all();
        end

        wr(2'd1, 32'h0004_0000);
        rd("t5_ovf_clr", 2'd1, 32'h0001_0000);
        for (int k = 0; k < 8; k++) wr(2'd0, 32'h30 + 32'(k));
        key_ready = 1'b1;
        wr(2'd0, 32'h55);
        key_ready = 1'b0;
        rd("t4_status", 2'd1, 32'h0002_0008);
        key_ready = 1'b1;
        repeat (8) tick();
        key_ready = 1'b0;
        rd_all();

        for (int k = 0; k < 3; k++) wr(2'd0, 32'h60 + 32'(k));
        key_ready = 1'b1;
        wr(2'd1, 32'h1);
        key_ready = 1'b0;
        chk("t5_flush_valid", {31'b0, key_valid}, 32'h0);
        rd("t5_flush_status", 2'd1, 32'h0001_0000);

        wr(2'd0, 32'hA1);
        wr(2'd0, 32'hA2);
        wr(2'd2, 32'h1D);
        chk("t6_held", {24'b0, held_key}, 32'h1D);
        rd_all();
        chk("t6_head", {24'b0, key_data}, 32'hA1);
        #2 reset_n = 1'b0;
        #1;
        q.delete(); m_last = '0; m_held = '0; m_ovf = 1'b0;
        chk("t6_rst_valid", {31'b0, key_valid}, 32'h0);
        chk("t6_rst_data", {24'b0, key_data}, 32'h0);
        chk("t6_rst_held", {24'b0, held_key}, 32'h0);
        rd_all();
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        wr(2'd0, 32'h77);
        chk("post_rst_data", {24'b0, key_data}, 32'h77);
        rd_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
